vip_uart_rx_mon: RTL

Multi-channel UART receive monitor for the SoC simulation fixture and FPGA debug harness. It decodes one or more DUT serial TX lines (8N1 or 8E1) with a runtime baud divisor. Each channel buffers received bytes in its own FIFO behind a valid/ready stream. It generalises the single hard-wired UART loopback to N channels, with framing, overflow and (optional) parity checking.

---
 rtl/vip_uart_rx_mon.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/vip_uart_rx_mon.sv
// vip_uart_rx_mon: multi-channel UART receive monitor.
// Each channel runs a 2-flop synchroniser, a receive FSM and a
// first-word-fall-through byte FIFO behind a valid/ready stream.
// Only the baud divisor div_i is shared between channels.
// Framing is 8N1 by default. Defining VIP_UART_RX_MON_PARITY_EN enables
// an even-parity bit between the data bits and the stop bit.
module vip_uart_rx_mon #(
    parameter int NumChan   = 1,
    parameter int DataBits  = 8,
    parameter int DivWidth  = 16,
    parameter int FifoDepth = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [DivWidth-1:0]         div_i,
    input  logic [NumChan-1:0]          en_i,
    input  logic [NumChan-1:0]          rx_i,
    output logic [NumChan*DataBits-1:0] data_o,
    output logic [NumChan-1:0]          valid_o,
    input  logic [NumChan-1:0]          ready_i,
    output logic [NumChan-1:0]          frame_err_o,
    output logic [NumChan-1:0]          parity_err_o,
    output logic [NumChan-1:0]          overflow_o,
    input  logic [NumChan-1:0]          clr_i
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = PtrW + 1;
    localparam int BitW = (DataBits > 1) ? $clog2(DataBits) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // Synchroniser chain and falling-edge register (all idle high)
    logic [NumChan-1:0] sync1_q, sync1_d;
    logic [NumChan-1:0] rxs_q, rxs_d;
    logic [NumChan-1:0] prev_q, prev_d;

    // Receive FSM state
    state_e              state_q [NumChan];
    state_e              state_d [NumChan];
    logic [DivWidth-1:0] cnt_q   [NumChan];
    logic [DivWidth-1:0] cnt_d   [NumChan];
    logic [DivWidth-1:0] dlen_q  [NumChan];
    logic [DivWidth-1:0] dlen_d  [NumChan];
    logic [BitW-1:0]     bit_q   [NumChan];
    logic [BitW-1:0]     bit_d   [NumChan];
    logic [DataBits-1:0] shift_q [NumChan];
    logic [DataBits-1:0] shift_d [NumChan];
    logic [NumChan-1:0]  par_bad_q, par_bad_d;
    logic [NumChan-1:0]  ferr_q, ferr_d;
    logic [NumChan-1:0]  perr_q, perr_d;
    logic [NumChan-1:0]  push;

    // FIFO state
    logic [DataBits-1:0] mem_q  [NumChan][FifoDepth];
    logic [PtrW-1:0]     wr_q   [NumChan];
    logic [PtrW-1:0]     wr_d   [NumChan];
    logic [PtrW-1:0]     rd_q   [NumChan];
    logic [PtrW-1:0]     rd_d   [NumChan];
    logic [CntW-1:0]     fill_q [NumChan];
    logic [CntW-1:0]     fill_d [NumChan];
    logic [DataBits-1:0] last_q [NumChan];
    logic [DataBits-1:0] last_d [NumChan];
    logic [NumChan-1:0]  ovf_q, ovf_d;
    logic [NumChan-1:0]  pop, accept;

    // Effective bit period: divisors below 4 are clamped so that d/2 >= 2
    logic [DivWidth-1:0] dmax;
    assign dmax = (div_i < DivWidth'(4)) ? DivWidth'(4) : div_i;

    // Receive FSM next-state: a count of 1 marks the sample cycle
    always_comb begin
        sync1_d   = rx_i;
        rxs_d     = sync1_q;
        prev_d    = rxs_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        dlen_d    = dlen_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        ferr_d    = '0;
        perr_d    = '0;
        push      = '0;
        for (int c = 0; c < NumChan; c++) begin
            if (!en_i[c]) begin
                state_d[c] = S_IDLE;
            end else begin
                case (state_q[c])
                    S_IDLE: begin
                        // Falling edge only: a line held low after a framing
                        // error must return high before a new frame starts.
                        if (prev_q[c] && !rxs_q[c]) begin
                            dlen_d[c]    = dmax;
                            cnt_d[c]     = dmax >> 1;
                            par_bad_d[c] = 1'b0;
                            state_d[c]   = S_START;
                        end
                    end
                    S_START: begin
                        if (cnt_q[c] == DivWidth'(1)) begin
                            if (rxs_q[c]) begin
                                state_d[c] = S_IDLE;
                            end else begin
                                cnt_d[c]   = dlen_q[c];
                                bit_d[c]   = '0;
                                state_d[c] = S_DATA;
                            end
                        end else begin
                            cnt_d[c] = cnt_q[c] - DivWidth'(1);
                        end
                    end
                    S_DATA: begin
                        if (cnt_q[c] == DivWidth'(1)) begin
                            shift_d[c] = {rxs_q[c], shift_q[c][DataBits-1:1]};
                            cnt_d[c]   = dlen_q[c];
                            if (bit_q[c] == BitW'(DataBits - 1)) begin
`ifdef VIP_UART_RX_MON_PARITY_EN
                                state_d[c] = S_PARITY;
`else
                                state_d[c] = S_STOP;
`endif
                            end else begin
                                bit_d[c] = bit_q[c] + BitW'(1);
                            end
                        end else begin
                            cnt_d[c] = cnt_q[c] - DivWidth'(1);
                        end
                    end
`ifdef VIP_UART_RX_MON_PARITY_EN
                    S_PARITY: begin
                        if (cnt_q[c] == DivWidth'(1)) begin
                            // Even parity: the parity bit equals the XOR of the data
                            par_bad_d[c] = (rxs_q[c] != (^shift_q[c]));
                            cnt_d[c]     = dlen_q[c];
                            state_d[c]   = S_STOP;
                        end else begin
                            cnt_d[c] = cnt_q[c] - DivWidth'(1);
                        end
                    end
`endif
                    S_STOP: begin
                        if (cnt_q[c] == DivWidth'(1)) begin
                            state_d[c] = S_IDLE;
                            if (!rxs_q[c]) begin
                                ferr_d[c] = 1'b1;
                            end else if (par_bad_q[c]) begin
                                perr_d[c] = 1'b1;
                            end else begin
                                push[c] = 1'b1;
                            end
                        end else begin
                            cnt_d[c] = cnt_q[c] - DivWidth'(1);
                        end
                    end
                    default: state_d[c] = S_IDLE;
                endcase
            end
        end
    end

    // FIFO bookkeeping: a push into a full FIFO is accepted only with a same-cycle pop
    always_comb begin
        pop    = '0;
        accept = '0;
        wr_d   = wr_q;
        rd_d   = rd_q;
        fill_d = fill_q;
        last_d = last_q;
        ovf_d  = ovf_q;
        for (int c = 0; c < NumChan; c++) begin
            pop[c]    = (fill_q[c] != '0) && ready_i[c];
            accept[c] = push[c] && ((fill_q[c] != CntW'(FifoDepth)) || pop[c]);
            wr_d[c]   = wr_q[c] + PtrW'(accept[c]);
            rd_d[c]   = rd_q[c] + PtrW'(pop[c]);
            fill_d[c] = fill_q[c] + CntW'(accept[c]) - CntW'(pop[c]);
            if (pop[c]) begin
                last_d[c] = mem_q[c][rd_q[c]];
            end
            // A drop in the same cycle as clr keeps the flag set
            if (push[c] && !accept[c]) begin
                ovf_d[c] = 1'b1;
            end else if (clr_i[c]) begin
                ovf_d[c] = 1'b0;
            end
        end
    end

    // Stream outputs: head of FIFO, or the last popped byte when empty
    always_comb begin
        valid_o = '0;
        data_o  = '0;
        for (int c = 0; c < NumChan; c++) begin
            valid_o[c] = (fill_q[c] != '0);
            data_o[c*DataBits +: DataBits] = (fill_q[c] != '0) ? mem_q[c][rd_q[c]] : last_q[c];
        end
    end

    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_q;
    assign overflow_o   = ovf_q;

    // Control state with asynchronous reset; reset aborts any frame in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= '1;
            rxs_q     <= '1;
            prev_q    <= '1;
            par_bad_q <= '0;
            ferr_q    <= '0;
            perr_q    <= '0;
            ovf_q     <= '0;
            for (int c = 0; c < NumChan; c++) begin
                state_q[c] <= S_IDLE;
                cnt_q[c]   <= '0;
                dlen_q[c]  <= '0;
                bit_q[c]   <= '0;
                wr_q[c]    <= '0;
                rd_q[c]    <= '0;
                fill_q[c]  <= '0;
                last_q[c]  <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            rxs_q     <= rxs_d;
            prev_q    <= prev_d;
            par_bad_q <= par_bad_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            ovf_q     <= ovf_d;
            for (int c = 0; c < NumChan; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                dlen_q[c]  <= dlen_d[c];
                bit_q[c]   <= bit_d[c];
                wr_q[c]    <= wr_d[c];
                rd_q[c]    <= rd_d[c];
                fill_q[c]  <= fill_d[c];
                last_q[c]  <= last_d[c];
            end
        end
    end

    // Data path storage: shift register and FIFO memory carry no reset
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumChan; c++) begin
            shift_q[c] <= shift_d[c];
            if (accept[c]) begin
                mem_q[c][wr_q[c]] <= shift_q[c];
            end
        end
    end

endmodule
